peripheral_mpram_spram: RTL and testbench
=========================================

Name: peripheral_mpram_spram

Overview:
- Single-port synchronous SRAM macro model fed directly by the AXI4 memory-side bus: req/we/addr/be/data in, read data out.
- Fixed one-cycle read latency, matching the bridge's requirement that read data is valid the cycle after a request, with no stall.
- Adds a post-reset zero-initialisation sweeper, out-of-range access detection with sticky error capture, and optional per-byte parity.

Parameters:
- ADDR_WIDTH, 64, byte-address width of addr_i
- DATA_WIDTH, 64, word width; multiple of 8
- MEM_WORDS, 1024, number of words in the array; power of two, at least 2
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  access request, one access per cycle
- we_i  in  1  1 = write, 0 = read; qualified by req_i
- addr_i  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
- be_i  in  DATA_WIDTH/8  byte write enables
- data_i  in  DATA_WIDTH  write data
- data_o  out  DATA_WIDTH  read data, registered
- init_done_o  out  1  high once the zero sweep has completed
- err_o  out  1  sticky out-of-range flag
- err_addr_o  out  ADDR_WIDTH  addr_i of the first out-of-range access since the last clear
- err_clr_i  in  1  clears err_o and err_addr_o

Behaviour:
- Reset (asynchronous):
  - data_o=0, init_done_o=0, err_o=0, err_addr_o=0.
  - FSM goes to INIT; sweep counter = 0.
  - Array contents are not reset.
- FSM state INIT:
  - Each cycle writes all-zero to word[cnt], then cnt+1.
  - After writing word MEM_WORDS-1, goes to READY; init_done_o rises the following cycle (exactly MEM_WORDS cycles after reset release).
  - req_i is ignored entirely: no write, data_o forced to 0, no error logged.
- FSM state READY: terminal until the next reset. Reset asserted mid-sweep restarts from word 0.
- Index and range:
  - off = addr_i - BASE_ADDR (ADDR_WIDTH wrap arithmetic); idx = off >> log2(DATA_WIDTH/8).
  - In range iff addr_i >= BASE_ADDR and idx < MEM_WORDS.
- Write (READY, req_i & we_i, in range):
  - At the clock edge, byte k of word[idx] is replaced by data_i byte k for every be_i[k]=1; other bytes are kept.
  - be_i=0 is a legal no-op.
  - data_o holds its previous value.
- Read (READY, req_i & ~we_i, in range):
  - data_o = word[idx] from the next cycle onward (1-cycle latency).
  - Back-to-back reads are supported every cycle.
  - be_i is ignored.
- Idle (req_i=0): data_o holds its last value indefinitely.
- Out of range (READY, req_i, any we_i):
  - Write is suppressed; a read returns data_o=0 next cycle.
  - If err_o=0: err_o is set and err_addr_o=addr_i. If err_o is already 1: err_addr_o is unchanged (first error wins).
- err_clr_i:
  - Clears err_o and err_addr_o next cycle.
  - If asserted in the same cycle as a new out-of-range access, the set wins and err_addr_o captures the new address.
- Read of a word written the previous cycle returns the new data; there is no hazard because writes commit at the edge.

Optional Feature:
- Macro: PERIPHERAL_MPRAM_SPRAM_PARITY_EN.
- Defined:
  - Array stores one even-parity bit per byte, computed from the written byte on each write; the sweep writes parity 0.
  - Extra output par_err_o (1 bit, reset 0) is registered alongside data_o.
  - par_err_o=1 for one cycle with the returned data when any byte's stored parity mismatches on an in-range read.
  - Stored parity bits are additionally exposed through hierarchical-reference-only array bits so the bench can corrupt them.
- Undefined: no parity storage, no par_err_o port.

Test Plan:
- Init: release reset with MEM_WORDS=16 -> init_done_o low for 16 cycles, high on cycle 17; a read issued during INIT gives data_o=0 and err_o stays 0; afterwards reading words 0..15 returns 0.
- Byte writes: write 0x1122334455667788 be=0xFF to addr 0x40, then 0xAAAA... with be=0x0F -> read of 0x40 gives 0x11223344AAAAAAAA on the cycle after the request.
- Back-to-back: write words 0..7 with value = index, then 8 consecutive reads -> data_o sequence 0..7 on consecutive cycles; data_o holds 7 with req_i low.
- Out of range: BASE_ADDR=0x1000, write to 0x0FF8 then read 0x1000+MEM_WORDS*8 -> err_o=1, err_addr_o=0x0FF8, read returns 0, no memory change; err_clr_i together with an access to 0x0 -> err_o=1, err_addr_o=0x0.
- Reset mid-sweep: assert rst_ni low at sweep cycle 5 -> all outputs 0 immediately; after release the sweep takes a full MEM_WORDS cycles.
- Parity (macro defined): write 0xFF to byte 0, flip its stored parity bit via the bench, read -> par_err_o=1 for exactly one cycle with the data; an uncorrupted read gives par_err_o=0.

Source files
------------

// File: rtl/peripheral_mpram_spram.sv
// peripheral_mpram_spram: single-port synchronous SRAM model for the AXI4
// memory-side bus. One-cycle registered read latency with no stall.
// After reset, a sweeper zeroes every word before any access is accepted.
// Out-of-range accesses are suppressed and logged in a sticky error register.
// Build option: define PERIPHERAL_MPRAM_SPRAM_PARITY_EN to add per-byte even
// parity storage and the par_err_o output.
module peripheral_mpram_spram #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
    output logic                    par_err_o,
`endif
    output logic                    init_done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    input  logic                    err_clr_i
);

    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(NB);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    sweep_we;
    logic                    init_done_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
    logic [NB-1:0]           par_mem [MEM_WORDS];
    logic [NB-1:0]           rd_par_calc;
    logic                    par_err_q;
`endif

    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic                    acc;
    logic                    wr_en;
    logic                    rd_acc;
    logic                    rd_en;
    logic                    oor;

    logic [DATA_WIDTH-1:0]   data_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;

    // Address decode: word index relative to the base, plus range check.
    always_comb begin
        off      = addr_i - BASE_ADDR;
        idx_full = off >> OFF_BITS;
        idx      = idx_full[IDX_W-1:0];
        in_range = (addr_i >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(MEM_WORDS));
        acc      = (state_q == ST_READY) && req_i;
        wr_en    = acc && we_i && in_range;
        rd_acc   = acc && !we_i;
        rd_en    = rd_acc && in_range;
        oor      = acc && !in_range;
    end

    // FSM state and sweep counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == ST_READY);
        end
    end

    // Next-state logic: sweep every word once, then stay ready until reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(MEM_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Array write port: sweep zeroes, otherwise byte-enabled writes.
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            mem[cnt_q] <= '0;
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
            par_mem[cnt_q] <= '0;
`endif
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= data_i[8*k +: 8];
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
                    par_mem[idx][k] <= ^data_i[8*k +: 8];
`endif
                end
            end
        end
    end

    // Registered read data; zero while sweeping and for out-of-range reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (state_q == ST_INIT) begin
            data_q <= '0;
        end else if (rd_acc) begin
            data_q <= in_range ? mem[idx] : '0;
        end
    end

    // Sticky error capture; a new out-of-range access overrides a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (oor) begin
            if (!err_q || err_clr_i) begin
                err_q      <= 1'b1;
                err_addr_q <= addr_i;
            end
        end else if (err_clr_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end
    end

`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
    // Recompute per-byte parity of the word being read.
    always_comb begin
        rd_par_calc = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            rd_par_calc[k] = ^mem[idx][8*k +: 8];
        end
    end

    // Parity error flag, valid for one cycle alongside the read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= rd_en && (|(rd_par_calc ^ par_mem[idx]));
        end
    end

    assign par_err_o = par_err_q;
`endif

    assign data_o      = data_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_peripheral_mpram_spram.sv
// Testbench for peripheral_mpram_spram: table vectors, hand sequences for
// init/reset/back-to-back corners, and random traffic against a word-array model.
module tb_peripheral_mpram_spram;

    localparam logic [63:0] BASE  = 64'h1000;
    localparam int unsigned WORDS = 16;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] data_i;
    logic [63:0] data_o;
    logic        init_done_o;
    logic        err_o;
    logic [63:0] err_addr_o;
    logic        err_clr_i;
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
    logic        par_err_o;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    logic [63:0] m_mem [WORDS];
    logic [63:0] m_data;
    logic        m_err;
    logic [63:0] m_ea;

    typedef struct {
        string       name;
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic        clr;
        logic [63:0] exp_data;
        logic        exp_err;
        logic [63:0] exp_ea;
    } vec_t;

    vec_t vecs [14];

    peripheral_mpram_spram #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MEM_WORDS  (WORDS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .data_i      (data_i),
        .data_o      (data_o),
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
        .par_err_o   (par_err_o),
`endif
        .init_done_o (init_done_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word array indexed by (addr-BASE)/8, updated per accepted access.
    task automatic model_step();
        logic [63:0] off;
        logic        inr;
        int unsigned w;
        off = addr_i - BASE;
        inr = (addr_i >= BASE) && ((off / 8) < 64'(WORDS));
        w   = inr ? 32'(off / 8) : 0;
        if (req_i && !inr) begin
            if (!we_i) m_data = 64'h0;
            if (!m_err || err_clr_i) begin
                m_err = 1'b1;
                m_ea  = addr_i;
            end
        end else begin
            if (err_clr_i) begin
                m_err = 1'b0;
                m_ea  = 64'h0;
            end
            if (req_i) begin
                if (we_i) begin
                    for (int b = 0; b < 8; b++)
                        if (be_i[b]) m_mem[w][8*b +: 8] = data_i[8*b +: 8];
                end else begin
                    m_data = m_mem[w];
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(WORDS); i++) m_mem[i] = 64'h0;
        m_data = 64'h0;
        m_err  = 1'b0;
        m_ea   = 64'h0;
    endtask

    task automatic cycle(input logic req, input logic we, input logic [63:0] addr,
                         input logic [7:0] be, input logic [63:0] data, input logic clr);
        @(negedge clk_i);
        req_i     = req;
        we_i      = we;
        addr_i    = addr;
        be_i      = be;
        data_i    = data;
        err_clr_i = clr;
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " data_o"}, data_o, m_data);
        check({tag, " err_o"}, 64'(err_o), 64'(m_err));
        check({tag, " err_addr_o"}, err_addr_o, m_ea);
    endtask

    // Called at a negedge right after reset release; requests during the sweep must be ignored.
    task automatic init_sweep(input string tag);
        for (int i = 0; i < int'(WORDS); i++) begin
            req_i = 1'b1;
            if (i % 2 == 0) begin
                we_i   = 1'b0;
                addr_i = BASE + 64'h8;
            end else begin
                we_i   = 1'b1;
                addr_i = 64'h0;
                be_i   = 8'hFF;
                data_i = '1;
            end
            @(posedge clk_i);
            #1;
            check({tag, " init_done_o"}, 64'(init_done_o), 64'(i == int'(WORDS) - 1));
            check({tag, " sweep data_o"}, data_o, 64'h0);
            check({tag, " sweep err_o"}, 64'(err_o), 64'h0);
            @(negedge clk_i);
        end
        req_i = 1'b0;
        we_i  = 1'b0;
        model_reset();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_ni    = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        be_i      = '0;
        data_i    = '0;
        err_clr_i = 1'b0;
        model_reset();

        vecs[0]  = '{"wr full",      1, 1, BASE + 64'h40, 8'hFF, 64'h1122334455667788, 0, 64'h0, 0, 64'h0};
        vecs[1]  = '{"wr low half",  1, 1, BASE + 64'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 64'h0, 0, 64'h0};
        vecs[2]  = '{"rd merged",    1, 0, BASE + 64'h40, 8'h00, 64'h0, 0, 64'h11223344AAAAAAAA, 0, 64'h0};
        vecs[3]  = '{"idle hold",    0, 0, 64'h0,         8'h00, 64'h0, 0, 64'h11223344AAAAAAAA, 0, 64'h0};
        vecs[4]  = '{"wr be0",       1, 1, BASE + 64'h48, 8'h00, 64'h5555555555555555, 0, 64'h11223344AAAAAAAA, 0, 64'h0};
        vecs[5]  = '{"rd be0 word",  1, 0, BASE + 64'h4C, 8'hFF, 64'h0, 0, 64'h0, 0, 64'h0};
        vecs[6]  = '{"oor wr below", 1, 1, 64'h0FF8,      8'hFF, 64'hDEAD, 0, 64'h0, 1, 64'h0FF8};
        vecs[7]  = '{"oor rd above", 1, 0, BASE + 64'h80, 8'h00, 64'h0, 0, 64'h0, 1, 64'h0FF8};
        vecs[8]  = '{"rd after oor", 1, 0, BASE + 64'h40, 8'h00, 64'h0, 0, 64'h11223344AAAAAAAA, 1, 64'h0FF8};
        vecs[9]  = '{"clr idle",     0, 0, 64'h0,         8'h00, 64'h0, 1, 64'h11223344AAAAAAAA, 0, 64'h0};
        vecs[10] = '{"clr+oor",      1, 1, 64'h0,         8'hFF, 64'h1, 1, 64'h11223344AAAAAAAA, 1, 64'h0};
        vecs[11] = '{"oor first win",1, 0, 64'hFFFFFFFFFFFFFFF8, 8'h00, 64'h0, 0, 64'h0, 1, 64'h0};
        vecs[12] = '{"clr+rd",       1, 0, BASE + 64'h40, 8'h00, 64'h0, 1, 64'h11223344AAAAAAAA, 0, 64'h0};
        vecs[13] = '{"rd last word", 1, 0, BASE + 64'h78, 8'h00, 64'h0, 0, 64'h0, 0, 64'h0};

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        check("rst data_o", data_o, 64'h0);
        check("rst init_done_o", 64'(init_done_o), 64'h0);
        check("rst err_o", 64'(err_o), 64'h0);
        check("rst err_addr_o", err_addr_o, 64'h0);

        @(negedge clk_i);
        rst_ni = 1'b1;
        init_sweep("init");

        for (int i = 0; i < int'(WORDS); i++) begin
            cycle(1'b1, 1'b0, BASE + 64'(i) * 8, 8'h00, 64'h0, 1'b0);
            check_model("post-init rd");
        end

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].clr);
            check({vecs[i].name, " data_o"}, data_o, vecs[i].exp_data);
            check({vecs[i].name, " err_o"}, 64'(err_o), 64'(vecs[i].exp_err));
            check({vecs[i].name, " err_addr_o"}, err_addr_o, vecs[i].exp_ea);
        end

        // Back-to-back writes then reads, then idle hold
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, BASE + 64'(i) * 8, 8'hFF, 64'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, BASE + 64'(i) * 8, 8'h00, 64'h0, 1'b0);
            check("b2b rd", data_o, 64'(i));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
            check("b2b hold", data_o, 64'h7);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 8) a = BASE + 64'($urandom_range(0, WORDS - 1)) * 8 + 64'($urandom_range(0, 7));
            else if (r == 8) a = {$urandom, $urandom};
            else a = ($urandom_range(0, 1) == 0) ? BASE - 64'h8 : BASE + 64'(WORDS) * 8 + 64'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                  8'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 15) == 0));
            check_model("rand");
            check("rand init_done_o", 64'(init_done_o), 64'h1);
`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
            check("rand par_err_o", 64'(par_err_o), 64'h0);
`endif
        end

        // Asynchronous reset from a non-zero state
        cycle(1'b1, 1'b1, BASE + 64'h40, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        cycle(1'b1, 1'b1, 64'h10, 8'hFF, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, BASE + 64'h40, 8'h00, 64'h0, 1'b0);
        check("pre-rst data_o", data_o, 64'hFFFFFFFFFFFFFFFF);
        check("pre-rst err_o", 64'(err_o), 64'h1);
        @(negedge clk_i);
        req_i     = 1'b0;
        err_clr_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("async rst data_o", data_o, 64'h0);
        check("async rst init_done_o", 64'(init_done_o), 64'h0);
        check("async rst err_o", 64'(err_o), 64'h0);
        check("async rst err_addr_o", err_addr_o, 64'h0);

        // Reset mid-sweep restarts the sweep from word 0
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("mid-sweep rst init_done_o", 64'(init_done_o), 64'h0);
        check("mid-sweep rst data_o", data_o, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        init_sweep("re-init");
        for (int i = 0; i < int'(WORDS); i++) begin
            cycle(1'b1, 1'b0, BASE + 64'(i) * 8, 8'h00, 64'h0, 1'b0);
            check_model("re-init rd");
        end

`ifdef PERIPHERAL_MPRAM_SPRAM_PARITY_EN
        cycle(1'b1, 1'b1, BASE, 8'h01, 64'hFF, 1'b0);
        dut.par_mem[0][0] = ~dut.par_mem[0][0];
        cycle(1'b1, 1'b0, BASE, 8'h00, 64'h0, 1'b0);
        check("par rd data_o", data_o, 64'hFF);
        check("par rd par_err_o", 64'(par_err_o), 64'h1);
        cycle(1'b0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        check("par idle par_err_o", 64'(par_err_o), 64'h0);
        check("par idle data_o", data_o, 64'hFF);
        cycle(1'b1, 1'b0, BASE + 64'h8, 8'h00, 64'h0, 1'b0);
        check("par clean par_err_o", 64'(par_err_o), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
